// File: rtl/rv_pkg.sv
// Shared register-writeback types: data/address widths and the queued load entry.
// Pure declarations; no timing or flow-control behaviour of its own.
package rv_pkg;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] rd;
    logic [WIDTH-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular queue of load results with rd-based live-clear and hazard match vectors.
// Head visible combinationally, push/pop take effect on the clock edge; push is ignored when full.
module wb_load_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  output wb_entry_t         head,
  output logic              full,
  output logic              empty,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_rd,
  input  logic [ADDR_W-1:0] q_rd1,
  input  logic [ADDR_W-1:0] q_rd2,
  output logic [DEPTH-1:0]  match1,
  output logic [DEPTH-1:0]  match2
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [PW-1:0]   wr_idx;
  logic [PW-1:0]   rd_idx;
  logic            push_ok;
  logic            pop_ok;

  assign wr_idx  = wr_ptr[PW-1:0];
  assign rd_idx  = rd_ptr[PW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_idx];

  // Slots outside the occupied range always hold live=0, so live alone qualifies a match.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = mem[i].live && (mem[i].rd == q_rd1);
      match2[i] = mem[i].live && (mem[i].rd == q_rd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // A newer write to the same rd (ALU or younger load) makes older queued data stale.
      for (int i = 0; i < DEPTH; i++) begin
        if ((kill_en && mem[i].rd == kill_rd) || (push_ok && mem[i].rd == push_entry.rd))
          mem[i].live <= 1'b0;
      end
      if (pop_ok) begin
        mem[rd_idx].live <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        mem[wr_idx] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter: in-order ALU results merged with queued load results.
// Write port registered (1 cycle after select); ALU stalls only on a forced drain, loads back-pressured when queue full.
module reg_writeback
  import rv_pkg::*;
#(
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  output logic              alu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  output logic              q_pend1,
  output logic              q_pend2,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_wa,
  output logic [WIDTH-1:0]  reg_wd
);

  localparam int              SW  = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0]   LIM = SW'(STARVE_LIM);

  logic                fifo_full;
  logic                fifo_empty;
  wb_entry_t           head;
  wb_entry_t           push_entry;
  logic                force_drain;
  logic                alu_take;
  logic                pop;
  logic                push;
  logic [SW-1:0]       starve_cnt;
  logic [LQ_DEPTH-1:0] match1;
  logic [LQ_DEPTH-1:0] match2;

  assign force_drain = !fifo_empty && (starve_cnt == LIM);
  assign alu_take    = alu_valid && !force_drain;
  assign pop         = force_drain || (!alu_valid && !fifo_empty);
  assign push        = ld_valid && !fifo_full;
  assign alu_stall   = force_drain;
  assign ld_ready    = !fifo_full;

  // A load arriving alongside an ALU write to the same rd is already stale.
  always_comb begin
    push_entry      = '0;
    push_entry.live = !(alu_take && (alu_rd == ld_rd));
    push_entry.rd   = ld_rd;
    push_entry.data = ld_data;
  end

  assign q_pend1 = (q_rs1 != '0) && ((|match1) || (push && (ld_rd == q_rs1)));
  assign q_pend2 = (q_rs2 != '0) && ((|match2) || (push && (ld_rd == q_rs2)));

  wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .kill_en    (alu_take),
    .kill_rd    (alu_rd),
    .q_rd1      (q_rs1),
    .q_rd2      (q_rs2),
    .match1     (match1),
    .match2     (match2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      starve_cnt <= '0;
    else if (fifo_empty || pop)   starve_cnt <= '0;
    else if (starve_cnt != LIM)   starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we <= 1'b0;
      reg_wa <= '0;
      reg_wd <= '0;
    end else if (pop) begin
      reg_we <= head.live && (head.rd != '0);
      reg_wa <= head.rd;
      reg_wd <= head.data;
    end else if (alu_take) begin
      reg_we <= (alu_rd != '0);
      reg_wa <= alu_rd;
      reg_wd <= alu_data;
    end else begin
      reg_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes queued at issue, popped by an independent monitor.
// Side checks cover stall/ready/hazard outputs and a shadow register file built from observed writes.
module tb_reg_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_pend1;
  logic        q_pend2;
  logic        reg_we;
  logic [4:0]  reg_wa;
  logic [31:0] reg_wd;

  int          errors = 0;
  int          checks = 0;
  logic [36:0] exp_q[$];
  logic [31:0] shadow [32];

  reg_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_pend1   (q_pend1),
    .q_pend2   (q_pend2),
    .reg_we    (reg_we),
    .reg_wa    (reg_wa),
    .reg_wd    (reg_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldat);
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
    ld_valid  = lv;
    ld_rd     = lr;
    ld_data   = ldat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every observed write must be the oldest outstanding expectation.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && reg_we === 1'b1) begin
        shadow[reg_wa] = reg_wd;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual wa=%0d wd=%0h required no write", reg_wa, reg_wd);
        end else begin
          e = exp_q.pop_front();
          chk("wb_write", 64'({reg_wa, reg_wd}), 64'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int ai;
    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    rst = 1'b1;
    idle();
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
    repeat (2) @(posedge clk);
    sample();
    chk("rst_we",    64'(reg_we),    64'(0));
    chk("rst_wa",    64'(reg_wa),    64'(0));
    chk("rst_wd",    64'(reg_wd),    64'(0));
    chk("rst_stall", 64'(alu_stall), 64'(0));
    chk("rst_ready", 64'(ld_ready),  64'(1));
    next();
    rst = 1'b0;

    // Mid-operation reset discards a queued load.
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'h12);
    q_rs1 = 5'd12;
    expect_wr(5'd9, 32'h99);
    sample();
    chk("t1_pend_incoming", 64'(q_pend1), 64'(1));
    next();
    idle();
    sample();
    chk("t1_we_before_rst", 64'(reg_we),  64'(1));
    chk("t1_pend_queued",   64'(q_pend1), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("t1_rst_we",    64'(reg_we),    64'(0));
    chk("t1_rst_wa",    64'(reg_wa),    64'(0));
    chk("t1_rst_wd",    64'(reg_wd),    64'(0));
    chk("t1_rst_stall", 64'(alu_stall), 64'(0));
    chk("t1_rst_pend",  64'(q_pend1),   64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    chk("t1_ready_after", 64'(ld_ready), 64'(1));
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("t1_no_we_after", 64'(reg_we), 64'(0));
    end
    next();

    // Single ALU write.
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd5, 32'h11);
    sample();
    chk("t2_stall", 64'(alu_stall), 64'(0));
    next();
    idle();
    sample();
    chk("t2_we", 64'(reg_we), 64'(1));
    chk("t2_wa", 64'(reg_wa), 64'(5));
    next();

    // Load with idle ALU: pending in accept cycle, written two cycles later.
    q_rs1 = 5'd7;
    q_rs2 = 5'd8;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hABCD);
    expect_wr(5'd7, 32'hABCD);
    sample();
    chk("t3_pend1",  64'(q_pend1),  64'(1));
    chk("t3_pend2",  64'(q_pend2),  64'(0));
    chk("t3_ready",  64'(ld_ready), 64'(1));
    next();
    idle();
    sample();
    chk("t3_we_early", 64'(reg_we),  64'(0));
    chk("t3_pend_q",   64'(q_pend1), 64'(1));
    next();
    sample();
    chk("t3_we",        64'(reg_we),  64'(1));
    chk("t3_wa",        64'(reg_wa),  64'(7));
    chk("t3_pend_gone", 64'(q_pend1), 64'(0));
    next();

    // Fill under continuous ALU traffic; starvation forces exactly one drain.
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
    for (int c = 0; c <= 13; c++) begin
      ai = (c == 10) ? 9 : c;
      drive(c <= 10, 5'(24 + ai % 4), 32'(32'h2000 + ai),
            c <= 4, 5'(16 + c), 32'(32'h100 + c));
      if (c <= 8 || c == 10) expect_wr(5'(24 + ai % 4), 32'(32'h2000 + ai));
      if (c == 9)            expect_wr(5'd16, 32'h100);
      if (c >= 11)           expect_wr(5'(16 + c - 10), 32'(32'h100 + c - 10));
      sample();
      chk("t4_stall", 64'(alu_stall), 64'(c == 9));
      if (c == 3)            chk("t4_ready_3", 64'(ld_ready), 64'(1));
      if (c >= 4 && c <= 9)  chk("t4_ready_full", 64'(ld_ready), 64'(0));
      next();
    end
    idle();
    repeat (3) next();

    // ALU write kills an older queued load to the same rd.
    q_rs1 = 5'd3;
    q_rs2 = 5'd3;
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h55);
    expect_wr(5'd4, 32'h44);
    sample();
    chk("t5_pend_in", 64'(q_pend1), 64'(1));
    next();
    drive(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd3, 32'h1);
    sample();
    chk("t5_pend_before_kill", 64'(q_pend2),   64'(1));
    chk("t5_stall",            64'(alu_stall), 64'(0));
    next();
    idle();
    sample();
    chk("t5_pend_killed", 64'(q_pend1), 64'(0));
    next();
    sample();
    chk("t5_killed_no_we", 64'(reg_we),    64'(0));
    chk("t5_x3",           64'(shadow[3]), 64'(1));
    next();

    // x0 targets: consumed without writes, never pending.
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
    drive(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'hFFFF);
    sample();
    chk("t6_pend1_x0", 64'(q_pend1), 64'(0));
    chk("t6_pend2_x0", 64'(q_pend2), 64'(0));
    next();
    idle();
    sample();
    chk("t6_alu_x0_we", 64'(reg_we),  64'(0));
    chk("t6_pend_x0_q", 64'(q_pend1), 64'(0));
    next();
    sample();
    chk("t6_ld_x0_we", 64'(reg_we), 64'(0));
    next();
    q_rs1 = 5'd13;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h1313);
    expect_wr(5'd13, 32'h1313);
    sample();
    chk("t6_pend13", 64'(q_pend1), 64'(1));
    next();
    idle();
    sample();
    chk("t6_empty_early", 64'(reg_we), 64'(0));
    next();
    sample();
    chk("t6_empty_lat", 64'(reg_we), 64'(1));
    next();

    // Same-cycle ALU and load to one rd: the load is enqueued stale.
    q_rs1 = 5'd8;
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 32'h77);
    expect_wr(5'd8, 32'h88);
    sample();
    chk("t7_pend_incoming", 64'(q_pend1), 64'(1));
    next();
    idle();
    sample();
    chk("t7_pend_stale", 64'(q_pend1), 64'(0));
    next();
    sample();
    chk("t7_no_we", 64'(reg_we), 64'(0));
    next();

    // Newer load to the same rd supersedes the older queued one.
    q_rs1 = 5'd11;
    drive(1'b1, 5'd20, 32'h1, 1'b1, 5'd11, 32'hA);
    expect_wr(5'd20, 32'h1);
    next();
    drive(1'b1, 5'd21, 32'h2, 1'b1, 5'd11, 32'hB);
    expect_wr(5'd21, 32'h2);
    expect_wr(5'd11, 32'hB);
    sample();
    chk("t8_pend_in", 64'(q_pend1), 64'(1));
    next();
    idle();
    sample();
    chk("t8_pend_newest", 64'(q_pend1), 64'(1));
    next();
    sample();
    chk("t8_older_no_we", 64'(reg_we),  64'(0));
    chk("t8_pend_head",   64'(q_pend1), 64'(1));
    next();
    sample();
    chk("t8_pend_done", 64'(q_pend1), 64'(0));
    next();

    repeat (4) next();
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    chk("x3_final",   64'(shadow[3]),  64'(1));
    chk("x8_final",   64'(shadow[8]),  64'(32'h88));
    chk("x11_final",  64'(shadow[11]), 64'(32'hB));
    chk("x12_never",  64'(shadow[12]), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
